// File: rtl/seg_capture.sv
// seg_capture: reads back a multiplexed, active-low 7-segment display bus.
// Each digit pattern must be stable for STABLE_CYCLES samples before it is
// decoded into a hex nibble plus decimal-point flag, and frame_valid pulses
// once every digit position has been captured.
// Optional feature macro: SEG_CAPTURE_TIMEOUT_EN (abandons a partial frame
// after TIMEOUT cycles without a capture).
module seg_capture #(
  parameter int DIGITS        = 6,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_data,
  input  logic [DIGITS-1:0]     seg_sel,
  output logic [4*DIGITS-1:0]   hex_data,
  output logic [DIGITS-1:0]     dp_data,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid,
  output logic                  timeout
);

  typedef enum logic {SETTLE, HOLD} state_t;

  localparam logic [7:0] CntLast = 8'(STABLE_CYCLES - 1);

  // Out-of-range parameter combinations land in this intentionally empty block
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || TIMEOUT < 2) begin : g_paramRangeViolation
  end

  logic [7:0]          r_segData;
  logic [DIGITS-1:0]   r_segSel;
  logic [7:0]          r_stableCnt;
  state_t              r_state;
  logic [4*DIGITS-1:0] r_hex;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_err;
  logic [DIGITS-1:0]   r_seen;
  logic                r_frameValid;

  logic                w_match;
  logic [DIGITS-1:0]   w_lowSel;
  logic                w_selOneLow;
  logic                w_capture;
  logic [DIGITS-1:0]   w_capMask;
  logic                w_known;
  logic [3:0]          w_nibble;
  logic                w_timeoutHit;

  assign w_match     = (seg_data == r_segData) && (seg_sel == r_segSel);
  assign w_lowSel    = ~r_segSel;
  assign w_selOneLow = (w_lowSel != '0) && ((w_lowSel & (w_lowSel - DIGITS'(1))) == '0);
  assign w_capture   = (r_state == SETTLE) && w_match && (r_stableCnt == CntLast) && w_selOneLow;
  assign w_capMask   = w_capture ? w_lowSel : '0;

  // Inverse 7-segment decode of the registered pattern (bits 6:0, active low)
  always_comb begin
    w_known  = 1'b1;
    w_nibble = 4'h0;
    case (r_segData[6:0])
      7'h40: w_nibble = 4'h0;
      7'h79: w_nibble = 4'h1;
      7'h24: w_nibble = 4'h2;
      7'h30: w_nibble = 4'h3;
      7'h19: w_nibble = 4'h4;
      7'h12: w_nibble = 4'h5;
      7'h02: w_nibble = 4'h6;
      7'h78: w_nibble = 4'h7;
      7'h00: w_nibble = 4'h8;
      7'h10: w_nibble = 4'h9;
      7'h08: w_nibble = 4'hA;
      7'h03: w_nibble = 4'hB;
      7'h46: w_nibble = 4'hC;
      7'h21: w_nibble = 4'hD;
      7'h06: w_nibble = 4'hE;
      7'h0E: w_nibble = 4'hF;
      default: begin
        w_known  = 1'b0;
        w_nibble = 4'h0;
      end
    endcase
  end

  // Register the bus every cycle and count how long it has stayed unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_segData   <= 8'hFF;
      r_segSel    <= '1;
      r_stableCnt <= 8'd0;
    end else begin
      r_segData <= seg_data;
      r_segSel  <= seg_sel;
      if (!w_match)
        r_stableCnt <= 8'd0;
      else if (r_stableCnt != CntLast)
        r_stableCnt <= r_stableCnt + 8'd1;
    end
  end

  // Capture FSM: one capture per stable interval, written into the selected digit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SETTLE;
      r_hex   <= '0;
      r_dp    <= '0;
      r_err   <= '0;
    end else begin
      case (r_state)
        SETTLE: if (w_capture) r_state <= HOLD;
        HOLD:   if (!w_match)  r_state <= SETTLE;
        default: r_state <= SETTLE;
      endcase
      for (int i = 0; i < DIGITS; i++) begin
        if (w_capMask[i]) begin
          r_hex[4*i +: 4] <= w_nibble;
          r_dp[i]         <= ~r_segData[7];
          r_err[i]        <= ~w_known;
        end
      end
    end
  end

  // Track which digits have been seen; pulse frame_valid the cycle after the set fills
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seen       <= '0;
      r_frameValid <= 1'b0;
    end else begin
      r_frameValid <= &r_seen;
      r_seen       <= ((&r_seen) ? '0 : r_seen) | w_capMask;
      if (w_timeoutHit)
        r_seen <= '0;
    end
  end

`ifdef SEG_CAPTURE_TIMEOUT_EN
  localparam int IdleW = $clog2(TIMEOUT) + 1;
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);

  logic [IdleW-1:0] r_idleCnt;
  logic             r_timeout;

  assign w_timeoutHit = !w_capture && (r_idleCnt == IdleLast);
  assign timeout      = r_timeout;

  // Idle counter abandons a partial frame after TIMEOUT cycles without a capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idleCnt <= '0;
      r_timeout <= 1'b0;
    end else if (w_capture) begin
      r_idleCnt <= '0;
      r_timeout <= 1'b0;
    end else if (r_idleCnt == IdleLast) begin
      r_idleCnt <= '0;
      r_timeout <= 1'b1;
    end else begin
      r_idleCnt <= r_idleCnt + IdleW'(1);
      r_timeout <= 1'b0;
    end
  end
`else
  assign w_timeoutHit = 1'b0;
  assign timeout      = 1'b0;
`endif

  assign hex_data    = r_hex;
  assign dp_data     = r_dp;
  assign digit_err   = r_err;
  assign frame_valid = r_frameValid;

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Reader for the multiplexed, active-low 7-segment display bus driven from our hex decode path.
- Samples the segment bus (seg_data) and active-low digit select (seg_sel), and waits for each pattern to be stable.
- Converts each stable pattern back to a 4-bit hex nibble and decimal-point flag per digit.
- Signals when a full frame has been captured. Used for loopback checking of display output on the spi_flash board design.

Parameters:
- DIGITS, 6, number of digit positions on seg_sel.
- STABLE_CYCLES, 4, consecutive identical samples required before capture (legal range 2..255).
- TIMEOUT, 100000, cycles without a capture before the frame is abandoned (used only with SEG_CAPTURE_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- seg_data  in  8  active-low segments; bit7 = dp, bits6:0 = g..a
- seg_sel  in  DIGITS  active-low digit enable; bit i = digit i
- hex_data  out  4*DIGITS  captured nibbles; digit i at [4i+3:4i]
- dp_data  out  DIGITS  captured dp per digit (1 = lit)
- digit_err  out  DIGITS  1 = last capture for that digit was an unknown pattern
- frame_valid  out  1  one-cycle pulse: every digit captured since last frame
- timeout  out  1  one-cycle pulse on frame abandonment (0 without the macro)

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk/rst. Reset is checked before all other logic, and applies mid-operation as well.
- Reset values: all outputs 0; sample register 0xFF / all-ones sel; stability counter 0; seen mask 0; FSM in SETTLE.
- Sample register: {seg_data, seg_sel} is registered every cycle.
  - match = incoming equals the registered value.
  - Counter: if match, increment (saturating at STABLE_CYCLES-1); otherwise clear to 0.
- FSM states: SETTLE and HOLD.
  - SETTLE -> HOLD when match, counter == STABLE_CYCLES-1, and registered seg_sel has exactly one bit low. The capture happens on that edge.
  - SETTLE, stable but seg_sel is all-ones (blank) or has more than one bit low: stay in SETTLE, no capture.
  - HOLD -> SETTLE on any mismatch. This gives exactly one capture per stable interval, however long it lasts.
- Latency: with inputs changed before edge E0, outputs update at edge E0+STABLE_CYCLES (5 edges for the default).
- Inverse decode, bits6:0 to nibble:
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F
- Capture into digit i:
  - dp_data[i] = ~seg_data[7].
  - Known pattern: write the nibble and clear digit_err[i].
  - Unknown pattern: write 0 and set digit_err[i]. dp is still captured.
  - Set seen mask bit i.
- Frame completion:
  - If the seen mask including the current capture is all ones, pulse frame_valid for one cycle on the edge after the capture and clear the mask.
  - A capture arriving on the clear cycle counts toward the next frame.
- Recapture of an already-seen digit overwrites its outputs. The mask is unaffected.
- Glitches shorter than STABLE_CYCLES samples never produce a capture.

Optional Feature:
- Macro: SEG_CAPTURE_TIMEOUT_EN.
- Defined:
  - An idle counter clears on every capture and increments otherwise.
  - When it reaches TIMEOUT-1: seen mask cleared, timeout pulses for one cycle, counter cleared.
  - hex_data, dp_data and digit_err are retained.
- Not defined: no idle counter; timeout tied to 0; a partial frame waits indefinitely.

Test Plan:
1. Reset, then drive seg_sel=6'b111110 and seg_data=8'hC0 (digit 0 showing "0"), held 4 cycles, then change. Expect no capture; all outputs still 0.
2. Hold seg_sel=6'b111110, seg_data=8'h79 for 20 cycles. Expect:
   - hex_data[3:0]=1, dp_data[0]=0, digit_err[0]=0 at edge E0+4.
   - Exactly one capture.
   - No frame_valid.
3. Scan digits 0..5 with 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h88 and 8'h0E (dp lit, "F"), each held 10 cycles. Expect:
   - hex_data=24'hF_A_5_4_3_2 (digit 5 down to digit 0).
   - dp_data=6'b100000.
   - One frame_valid pulse the cycle after digit 5's capture.
   - A second identical scan gives a second pulse.
4. Digit 2 with seg_data=8'hFF (blank pattern), held 10 cycles. Expect hex_data[11:8]=0 and digit_err[2]=1. A later 8'h86 capture gives nibble E and clears digit_err[2].
5. seg_sel=6'b111100 (two digits) or 6'b111111 (blank), held 20 cycles. Expect no capture and the seen mask unchanged. Assert rst mid-scan: all outputs 0 next cycle, and a partial frame never pulses frame_valid.
6. With SEG_CAPTURE_TIMEOUT_EN and TIMEOUT=50: capture digits 0..2, then idle. Expect:
   - timeout pulses 50 cycles after the last capture.
   - A following full scan of digits 0..5 pulses frame_valid once; digits 0..2 are not credited from the old frame.
